// File: rtl/auth_pkg.sv
// Shared types and default command bytes for the
// BLE authorisation / power sequencer.
package auth_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    PWR1 = 2'b01,
    PWR2 = 2'b10
  } auth_state_t;

  localparam logic [7:0] CMD_GO   = 8'h67;
  localparam logic [7:0] CMD_STOP = 8'h73;

endpackage

// File: rtl/rider_off_filter.sv
// Rider-off vote + debounce: all sources must report off for
// OFF_DLY consecutive cycles. Ports: clk, rst_n, rider_off[N_SRC], rider_off_q.
module rider_off_filter #(
  parameter int N_SRC   = 2,
  parameter int OFF_DLY = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] rider_off,
  output logic             rider_off_q
);

  localparam int CW = $clog2(OFF_DLY + 1);
  localparam logic [CW-1:0] CMAX = CW'(OFF_DLY);

  logic          all_off;
  logic [CW-1:0] off_cnt;

  assign all_off = &rider_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_cnt <= '0;
    end else if (!all_off) begin
      off_cnt <= '0;
    end else if (off_cnt != CMAX) begin
      off_cnt <= off_cnt + CW'(1);
    end
  end

  assign rider_off_q = (off_cnt == CMAX);

endmodule

// File: rtl/auth_pwr_seq.sv
// Command-driven power sequencer with rider-off stop hold and idle
// auto power-down. Ports: clk, rst_n, rx_rdy, rx_data, rider_off,
// clr_rx_rdy, pwr_up, auto_off, state.
module auth_pwr_seq
  import auth_pkg::*;
#(
  parameter logic [7:0] GO_CMD   = CMD_GO,
  parameter logic [7:0] STOP_CMD = CMD_STOP,
  parameter int         N_SRC    = 2,
  parameter int         OFF_DLY  = 16,
  parameter int         IDLE_TMO = 2**24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_rdy,
  input  logic [7:0]       rx_data,
  input  logic [N_SRC-1:0] rider_off,
  output logic             clr_rx_rdy,
  output logic             pwr_up,
  output logic             auto_off,
  output logic [1:0]       state
);

  // A zero timeout still needs a 1-bit counter to stay legal.
  localparam int IW = (IDLE_TMO > 0) ?
                      $clog2(IDLE_TMO + 1) : 1;
  localparam logic [IW-1:0] IMAX  = IW'(IDLE_TMO);
  localparam logic [IW-1:0] ILAST = IW'(IDLE_TMO - 1);
  localparam bit            TMO_EN = (IDLE_TMO != 0);

  auth_state_t   st, nxt;
  logic          rider_off_q;
  logic          go, stop;
  logic          counting, idle_exp;
  logic          auto_nxt;
  logic [IW-1:0] idle_cnt;

  rider_off_filter #(
    .N_SRC  (N_SRC),
    .OFF_DLY(OFF_DLY)
  ) u_filt (
    .clk        (clk),
    .rst_n      (rst_n),
    .rider_off  (rider_off),
    .rider_off_q(rider_off_q)
  );

  // Every byte is consumed, recognised or not.
  assign clr_rx_rdy = rx_rdy;

  assign go   = rx_rdy && (rx_data == GO_CMD);
  assign stop = rx_rdy && (rx_data == STOP_CMD);

  // Any received byte counts as activity.
  assign counting = (st == PWR1) && rider_off_q && !rx_rdy;
  assign idle_exp = TMO_EN && counting &&
                    (idle_cnt == ILAST);

  always_comb begin
    nxt      = st;
    auto_nxt = 1'b0;
    unique case (st)
      OFF: begin
        if (go) nxt = PWR1;
      end
      PWR1: begin
        if (stop) begin
          nxt = rider_off_q ? OFF : PWR2;
        end else if (idle_exp) begin
          nxt      = OFF;
          auto_nxt = 1'b1;
        end
      end
      PWR2: begin
        // GO cancels the pending stop even if rider leaves now.
        if (go)               nxt = PWR1;
        else if (rider_off_q) nxt = OFF;
      end
      default: nxt = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= OFF;
      pwr_up   <= 1'b0;
      auto_off <= 1'b0;
    end else begin
      st       <= nxt;
      pwr_up   <= (nxt != OFF);
      auto_off <= auto_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (!counting) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IMAX) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign state = st;

endmodule

// File: doc/auth_pwr_seq.md
Name: auth_pwr_seq

Overview:
Parametrised successor to the Segway authorisation block. It consumes command bytes from the BLE UART receiver and drives pwr_up to the steering/balance path. It adds configurable command codes, an N-source rider-presence vote, and a debounce on rider-off. It also adds an idle auto-power-down that the current block lacks. It sits between UART_rcv and steer_en/balance_cntrl inside Segway.

Parameters:
GO_CMD, 8'h67, byte that requests power-up ('g')
STOP_CMD, 8'h73, byte that requests power-down ('s')
N_SRC, 2, number of rider-off sources (e.g. left/right load-cell comparators)
OFF_DLY, 16, consecutive cycles all sources must report off before rider counts as off (>=1)
IDLE_TMO, 2**24, cycles of filtered rider-off in PWR1 before auto power-down; 0 disables

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx_rdy  input  1  UART byte available
rx_data  input  8  UART byte
rider_off  input  N_SRC  per-source rider-off flags, active high
clr_rx_rdy  output  1  consume strobe to UART, combinational
pwr_up  output  1  power enable, registered
auto_off  output  1  one-cycle pulse on idle-timeout power-down, registered
state  output  2  current state, debug

Behaviour:
- Reset values: state=OFF, pwr_up=0, auto_off=0, all counters 0. clr_rx_rdy follows rx_rdy, so it is 0 while rx_rdy=0.
- Reset asserted mid-operation forces OFF immediately (async), whatever the state or counter values.
- clr_rx_rdy=rx_rdy in the same cycle. Every byte is consumed, including unrecognised bytes, which cause no state change.
- rider_all_off = &rider_off.
- off_cnt increments each cycle rider_all_off=1 and saturates at OFF_DLY. It clears to 0 on any cycle rider_all_off=0.
- rider_off_q = (off_cnt==OFF_DLY). It first asserts OFF_DLY cycles after rider_all_off rises.
- idle_cnt runs only in PWR1 while rider_off_q=1. It clears on leaving PWR1, on rider_off_q=0, and on any rx_rdy cycle.
- idle_exp = (IDLE_TMO!=0) && (idle_cnt==IDLE_TMO-1) && counting.
- Counter widths are $clog2(max+1). There is no wrap; counters saturate or clear.
- States:
  - OFF: rx GO_CMD -> PWR1. All else stays in OFF.
  - PWR1: rx STOP_CMD with rider_off_q=1 -> OFF. rx STOP_CMD with rider_off_q=0 -> PWR2. idle_exp -> OFF and pulse auto_off.
  - PWR2 (stop pending): rx GO_CMD -> PWR1 (cancels the stop). rider_off_q=1 -> OFF.
- Simultaneous events:
  - PWR2 with GO_CMD and rider_off_q=1 in the same cycle: GO wins, next state PWR1.
  - PWR1 with STOP_CMD and idle_exp in the same cycle: next state OFF, auto_off=0 (command-driven shutdown).
  - rx_rdy in the idle_exp cycle clears the counter, so there is no expiry that cycle.
- Latency: pwr_up is registered as (next_state!=OFF). It updates on the edge ending the cycle in which rx_rdy or the rider condition is seen. auto_off shares that edge.
- Re-sending GO_CMD in PWR1, or STOP_CMD in PWR2, changes no state but does clear idle_cnt.
- Re-sending GO_CMD while already powered never drops pwr_up, even for one cycle.

Decomposition:
- Package auth_pkg holds:
  - typedef enum logic [1:0] {OFF=2'b00, PWR1=2'b01, PWR2=2'b10} auth_state_t;
  - default command constants CMD_GO and CMD_STOP.
- One sub-module, rider_off_filter (params N_SRC, OFF_DLY). It contains the AND-vote and the saturating debounce, and outputs rider_off_q.
- The FSM and idle timer stay in auth_pwr_seq.

Test Plan (bench params OFF_DLY=4, IDLE_TMO=64, N_SRC=2):
- Power-up with rider off: rider_off=2'b11, send 8'h67 -> pwr_up=1 one cycle after rx_rdy. State goes PWR1, and rider_off has no effect on power-up.
- Stop held by rider: rider_off=2'b00, send 8'h73 -> state=PWR2, pwr_up stays 1. Then rider_off=2'b11 -> pwr_up=0 exactly 4 cycles later (plus 1 register), state=OFF.
- Partial vote and glitch: in PWR2 set rider_off=2'b01 for 100 cycles -> pwr_up stays 1. A 3-cycle 2'b11 pulse -> pwr_up stays 1.
- Stop cancel: in PWR2, send 8'h67 -> PWR1. Then rider_off=2'b11 for 200 cycles with no bytes -> auto_off pulses once at cycle 4+64 and pwr_up=0. Repeat sending 8'h41 every 50 cycles -> no auto_off (idle timer cleared).
- Boundaries:
  - In PWR2 assert GO_CMD the same cycle rider_off_q rises -> state=PWR1.
  - In PWR1 send STOP_CMD on the idle_exp cycle -> OFF with auto_off=0.
  - Pull rst_n low in PWR2 -> pwr_up=0 asynchronously, and state=OFF.
